// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback queue: register-file geometry and
// the queued write entry.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] mask;
        mask     = {NUM_REGS{1'b0}};
        mask[rd] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Writeback bus: load and ALU result handshakes in, register-file write and
// queue status out.
interface writeback_queue_if;
    import wb_pkg::*;

    logic                  ld_valid;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  ld_ready;
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;
    logic                  reg_we;
    logic [REG_ADDR_W-1:0] reg_wr;
    logic [XLEN-1:0]       reg_wdata;
    logic [NUM_REGS-1:0]   busy_mask;
    logic                  full;
    logic                  empty;

    modport master (
        output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
        input  ld_ready, alu_ready, reg_we, reg_wr, reg_wdata, busy_mask, full, empty
    );

    modport slave (
        input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
        output ld_ready, alu_ready, reg_we, reg_wr, reg_wdata, busy_mask, full, empty
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO of pending register writes; exposes its storage and per-slot
// valid bits so the owner can build the busy mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head_entry,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      valid_mask,
    output wb_entry_t [DEPTH-1:0] entries
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem_r;
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == CNT_W'(0));
    assign push_ok_s  = push && !full;
    assign pop_ok_s   = pop && !empty;
    assign head_entry = mem_r[head_r];
    assign entries    = mem_r;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r   <= '{default: '0};
            head_r  <= PTR_W'(0);
            tail_r  <= PTR_W'(0);
            count_r <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[tail_r] <= push_entry;
                tail_r        <= tail_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // A slot holds a live entry when its distance from head is below the count.
    always_comb begin
        valid_mask = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask[i] = ({1'b0, PTR_W'(i) - head_r} < count_r);
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback arbiter: load/ALU results are queued and retired one
// per cycle. Define WB_BYPASS_EN to let a write skip an empty queue.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    writeback_queue_if.slave  bus
);

    wb_entry_t             ld_entry_s;
    wb_entry_t             alu_entry_s;
    wb_entry_t             sel_entry_s;
    wb_entry_t             head_entry_s;
    wb_entry_t [DEPTH-1:0] entries_s;
    logic [DEPTH-1:0]      valid_mask_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  ld_ready_s;
    logic                  alu_ready_s;
    logic                  ld_xfer_s;
    logic                  alu_xfer_s;
    logic                  live_s;
    logic                  bypass_s;
    logic                  push_s;
    logic                  pop_s;
    logic [NUM_REGS-1:0]   busy_s;

    logic                  reg_we_r;
    logic [REG_ADDR_W-1:0] reg_wr_r;
    logic [XLEN-1:0]       reg_wdata_r;

    assign ld_entry_s  = '{rd: bus.ld_rd,  data: bus.ld_data};
    assign alu_entry_s = '{rd: bus.alu_rd, data: bus.alu_data};

    // Readiness comes from the registered count, so a same-edge pop never frees a slot.
    assign ld_ready_s  = !fifo_full_s;
    assign alu_ready_s = !fifo_full_s && !bus.ld_valid;
    assign ld_xfer_s   = bus.ld_valid && ld_ready_s;
    assign alu_xfer_s  = bus.alu_valid && alu_ready_s;
    assign sel_entry_s = ld_xfer_s ? ld_entry_s : alu_entry_s;
    // Writes to r0 are handshaken but dropped.
    assign live_s      = (ld_xfer_s || alu_xfer_s) && (sel_entry_s.rd != REG_ADDR_W'(0));
    assign pop_s       = !fifo_empty_s;

`ifdef WB_BYPASS_EN
    assign bypass_s = live_s && fifo_empty_s;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s = live_s && !bypass_s;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_entry (sel_entry_s),
        .pop        (pop_s),
        .head_entry (head_entry_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .valid_mask (valid_mask_s),
        .entries    (entries_s)
    );

    // Output register: one-cycle write pulse; address and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we_r    <= 1'b0;
            reg_wr_r    <= REG_ADDR_W'(0);
            reg_wdata_r <= XLEN'(0);
        end else if (pop_s) begin
            reg_we_r    <= 1'b1;
            reg_wr_r    <= head_entry_s.rd;
            reg_wdata_r <= head_entry_s.data;
        end else if (bypass_s) begin
            reg_we_r    <= 1'b1;
            reg_wr_r    <= sel_entry_s.rd;
            reg_wdata_r <= sel_entry_s.data;
        end else begin
            reg_we_r    <= 1'b0;
        end
    end

    // Pending-write scoreboard for hazard detection: queued entries plus the write in flight.
    always_comb begin
        busy_s = reg_we_r ? rd_onehot(reg_wr_r) : {NUM_REGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            busy_s = busy_s | (valid_mask_s[i] ? rd_onehot(entries_s[i].rd) : {NUM_REGS{1'b0}});
        end
    end

    assign bus.ld_ready  = ld_ready_s;
    assign bus.alu_ready = alu_ready_s;
    assign bus.reg_we    = reg_we_r;
    assign bus.reg_wr    = reg_wr_r;
    assign bus.reg_wdata = reg_wdata_r;
    assign bus.busy_mask = busy_s;
    assign bus.full      = fifo_full_s;
    assign bus.empty     = fifo_empty_s;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: vector table of single writes, a
// scoreboard of expected register writes, and multi-cycle corner sequences.
module tb_writeback_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic        is_ld;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_we;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] last_rd = 5'd0;
    wb_entry_t sb_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    writeback_queue_if bus();

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b0;
    endtask

    function automatic logic [31:0] onehot32(input logic [4:0] rd);
        logic [31:0] m;
        m = 32'd0;
        if (rd != 5'd0) m[rd] = 1'b1;
        return m;
    endfunction

    // Scoreboard consumer: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.reg_we) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wb_entry_t e;
                e = sb_q.pop_front();
                check("wr_rd", 32'(bus.reg_wr), 32'(e.rd));
                check("wr_data", bus.reg_wdata, e.data);
                last_rd = e.rd;
            end
        end
    end

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check({name, "_empty"}, 32'(bus.empty), 32'd1);
        check({name, "_busy_clear"}, bus.busy_mask, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n, input logic [31:0] base, input string name);
        int   j;
        int   budget;
        logic rdy;
        j = 0;
        budget = 0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'(j % 31 + 1);
        bus.alu_data  = base + 32'(j) * 32'h01010101;
        while (j < n && budget < 100) begin
            @(negedge clk);
            budget++;
            rdy = bus.alu_ready;
            check({name, "_full"}, 32'(bus.full), 32'd0);
            if (budget > LAT) check({name, "_we_sustained"}, 32'(bus.reg_we), 32'd1);
            @(posedge clk);
            if (rdy) begin
                sb_q.push_back('{rd: bus.alu_rd, data: bus.alu_data});
                j++;
            end
            #1;
            if (j < n) begin
                bus.alu_rd   = 5'(j % 31 + 1);
                bus.alu_data = base + 32'(j) * 32'h01010101;
            end else begin
                bus.alu_valid = 1'b0;
            end
        end
        if (j < n) check({name, "_timeout"}, 32'(j), 32'(n));
        bus.alu_valid = 1'b0;
    endtask

    initial begin
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = 5'd0;
        bus.ld_data   = 32'd0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'd0;

        vecs[0] = '{1'b0, 5'd5,  32'hDEADBEEF, 1'b1};
        vecs[1] = '{1'b1, 5'd7,  32'h0000_1234, 1'b1};
        vecs[2] = '{1'b0, 5'd0,  32'h1234_5678, 1'b0};
        vecs[3] = '{1'b1, 5'd0,  32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{1'b1, 5'd1,  32'h0000_0001, 1'b1};

        // Reset state, with ld_valid raised to observe alu_ready gating.
        bus.ld_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_reg_we", 32'(bus.reg_we), 32'd0);
        check("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        check("rst_reg_wdata", bus.reg_wdata, 32'd0);
        check("rst_busy", bus.busy_mask, 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_alu_ready_ld", 32'(bus.alu_ready), 32'd0);
        bus.ld_valid = 1'b0;
        #1;
        check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven single writes from an empty queue.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_busy;
            exp_busy = onehot32(vecs[i].rd);
            if (vecs[i].is_ld) begin
                bus.ld_valid = 1'b1;
                bus.ld_rd    = vecs[i].rd;
                bus.ld_data  = vecs[i].data;
            end else begin
                bus.alu_valid = 1'b1;
                bus.alu_rd    = vecs[i].rd;
                bus.alu_data  = vecs[i].data;
            end
            if (vecs[i].rd != 5'd0) sb_q.push_back('{rd: vecs[i].rd, data: vecs[i].data});
            @(negedge clk);
            check("vec_ld_ready", 32'(bus.ld_ready), 32'd1);
            check("vec_alu_ready", 32'(bus.alu_ready), 32'(!vecs[i].is_ld));
            @(posedge clk); #1;
            idle();
            for (int l = 1; l <= LAT; l++) begin
                @(negedge clk);
                check("vec_we", 32'(bus.reg_we), 32'((l == LAT) && vecs[i].exp_we));
                check("vec_busy", bus.busy_mask, exp_busy);
            end
            @(negedge clk);
            check("vec_we_off", 32'(bus.reg_we), 32'd0);
            check("vec_busy_off", bus.busy_mask, 32'd0);
            check("vec_hold_rd", 32'(bus.reg_wr), 32'(last_rd));
            @(posedge clk); #1;
        end

        // Simultaneous load and ALU: load wins, ALU accepted on the next edge.
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd3;
        bus.ld_data   = 32'h3333_0003;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd4;
        bus.alu_data  = 32'h4444_0004;
        sb_q.push_back('{rd: 5'd3, data: 32'h3333_0003});
        sb_q.push_back('{rd: 5'd4, data: 32'h4444_0004});
        @(negedge clk);
        check("prio_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("prio_alu_ready", 32'(bus.alu_ready), 32'd0);
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        @(negedge clk);
        check("prio_alu_ready_next", 32'(bus.alu_ready), 32'd1);
        check("prio_we_n1", 32'(bus.reg_we), 32'(LAT == 1));
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        @(negedge clk);
        check("prio_we_n2", 32'(bus.reg_we), 32'd1);
        check("prio_wr_n2", 32'(bus.reg_wr), (LAT == 1) ? 32'd4 : 32'd3);
        @(posedge clk); #1;
        drain("prio");

        // Back-to-back stream rd=1..4, then a 2*DEPTH+1 stream across pointer wrap.
        stream(4, 32'hB000_0000, "burst4");
        drain("burst4");
        stream(2 * DEPTH + 1, 32'hA500_0000, "wrap");
        drain("wrap");

        // Reset mid-stream: queued and in-flight writes are discarded.
        stream(3, 32'hC000_0000, "rstmid");
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("rstmid_reg_we", 32'(bus.reg_we), 32'd0);
        check("rstmid_reg_wr", 32'(bus.reg_wr), 32'd0);
        check("rstmid_wdata", bus.reg_wdata, 32'd0);
        check("rstmid_busy", bus.busy_mask, 32'd0);
        check("rstmid_empty", 32'(bus.empty), 32'd1);
        check("rstmid_full", 32'(bus.full), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rstmid_no_we", 32'(bus.reg_we), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
